// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the decode-side instruction queue.
// Issue-mode encodings mirror the core-wide DualIssue/SingleIssue defines.
package inst_queue_pkg;

    localparam int   IQ_DEPTH          = 16;
    localparam int   SIZE_OF_CORR_PACK = 88;
    localparam logic DUAL_ISSUE        = 1'b1;
    localparam logic SINGLE_ISSUE      = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0;

    typedef struct packed {
        logic [31:0]                  inst;
        logic [31:0]                  addr;
        logic [SIZE_OF_CORR_PACK-1:0] corr;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side write bus plus decode-side issue/readout bus of the instruction queue.
// slave = the queue itself, master = fetch/decode (or a bench).
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
);
    logic                          flush_i;
    logic [31:0]                   fetch_inst1_i, fetch_inst2_i;
    logic [31:0]                   fetch_addr1_i, fetch_addr2_i;
    logic [SIZE_OF_CORR_PACK-1:0]  fetch_corr1_i, fetch_corr2_i;
    logic                          fetch_valid1_i, fetch_valid2_i;
    logic                          full_o;
    logic                          issue_mode_i;
    logic                          issued_i;
    logic                          ninst_in_delayslot_i;
    logic [31:0]                   inst1_o, inst2_o;
    logic [31:0]                   inst1_addr_o, inst2_addr_o;
    logic [SIZE_OF_CORR_PACK-1:0]  inst1_corr_o, inst2_corr_o;
    logic                          issue_en_o;
    logic                          is_in_delayslot_o;
    logic [$clog2(DEPTH):0]        count_o;

    modport slave (
        input  flush_i, fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
               fetch_corr1_i, fetch_corr2_i, fetch_valid1_i, fetch_valid2_i,
               issue_mode_i, issued_i, ninst_in_delayslot_i,
        output full_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
               inst1_corr_o, inst2_corr_o, issue_en_o, is_in_delayslot_o, count_o
    );

    modport master (
        output flush_i, fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
               fetch_corr1_i, fetch_corr2_i, fetch_valid1_i, fetch_valid2_i,
               issue_mode_i, issued_i, ninst_in_delayslot_i,
        input  full_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
               inst1_corr_o, inst2_corr_o, issue_en_o, is_in_delayslot_o, count_o
    );
endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage: register array, two write ports (tail, tail+1), two async read ports.
// No reset: stale contents are masked by the occupancy count in the queue.
module iq_entry_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  iq_entry_t       wdat1_i,
    input  logic            we2_i,
    input  logic [AW-1:0]   waddr2_i,
    input  iq_entry_t       wdat2_i,
    input  logic [AW-1:0]   raddr1_i,
    output iq_entry_t       rdat1_o,
    input  logic [AW-1:0]   raddr2_i,
    output iq_entry_t       rdat2_o
);
    iq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we1_i) mem_q[waddr1_i] <= wdat1_i;
        if (we2_i) mem_q[waddr2_i] <= wdat2_i;
    end

    assign rdat1_o = mem_q[raddr1_i];
    assign rdat2_o = mem_q[raddr2_i];
endmodule

// File: rtl/inst_queue.sv
// Dual-write / dual-read instruction queue between fetch and decode, with delay-slot tracking.
// Optional IQ_PERF_CNT_EN adds saturating empty/single-pop/dual-pop cycle counters.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    inst_queue_if.slave iq_if
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_empty_o,
    output logic [31:0] perf_single_o,
    output logic [31:0] perf_dual_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] push_n, pop_req, pop_n;
    logic          ds_q, ds_d;
    logic          full;
    iq_entry_t     wdat1, wdat2, rdat1, rdat2, out1, out2;

    // Two free slots are always required so a dual fetch never needs splitting.
    assign full = count_q >= CW'(DEPTH - 1);

    always_comb begin
        push_n  = '0;
        pop_req = '0;
        if (!full && iq_if.fetch_valid1_i)
            push_n = iq_if.fetch_valid2_i ? CW'(2) : CW'(1);
        if (iq_if.issued_i)
            pop_req = (iq_if.issue_mode_i == DUAL_ISSUE) ? CW'(2) : CW'(1);
        pop_n   = (pop_req > count_q) ? count_q : pop_req;

        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push_n);
        count_d = count_q + push_n - pop_n;

        // The flag survives empty cycles; only an actual pop of the slot clears it.
        ds_d = ds_q;
        if (iq_if.issued_i && iq_if.issue_mode_i == SINGLE_ISSUE && iq_if.ninst_in_delayslot_i)
            ds_d = 1'b1;
        else if (pop_n != '0)
            ds_d = 1'b0;

        if (iq_if.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ds_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ds_q    <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ds_q    <= ds_d;
        end
    end

    assign wdat1 = '{inst: iq_if.fetch_inst1_i, addr: iq_if.fetch_addr1_i, corr: iq_if.fetch_corr1_i};
    assign wdat2 = '{inst: iq_if.fetch_inst2_i, addr: iq_if.fetch_addr2_i, corr: iq_if.fetch_corr2_i};

    iq_entry_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk      (clk),
        .we1_i    (!rst && !iq_if.flush_i && push_n != '0),
        .waddr1_i (tail_q),
        .wdat1_i  (wdat1),
        .we2_i    (!rst && !iq_if.flush_i && push_n == CW'(2)),
        .waddr2_i (tail_q + AW'(1)),
        .wdat2_i  (wdat2),
        .raddr1_i (head_q),
        .rdat1_o  (rdat1),
        .raddr2_i (head_q + AW'(1)),
        .rdat2_o  (rdat2)
    );

    assign out1 = (count_q != '0)      ? rdat1 : '0;
    assign out2 = (count_q >= CW'(2))  ? rdat2 : '0;

    assign iq_if.inst1_o           = out1.inst;
    assign iq_if.inst1_addr_o      = out1.addr;
    assign iq_if.inst1_corr_o      = out1.corr;
    assign iq_if.inst2_o           = out2.inst;
    assign iq_if.inst2_addr_o      = out2.addr;
    assign iq_if.inst2_corr_o      = out2.corr;
    assign iq_if.full_o            = full;
    assign iq_if.issue_en_o        = count_q >= CW'(2);
    assign iq_if.is_in_delayslot_o = ds_q && (count_q != '0);
    assign iq_if.count_o           = count_q;

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_empty_q, perf_single_q, perf_dual_q;

    // Pops squashed by a flush are not counted as issue activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_empty_q  <= '0;
            perf_single_q <= '0;
            perf_dual_q   <= '0;
        end else begin
            if (count_q == '0 && perf_empty_q != '1)
                perf_empty_q <= perf_empty_q + 32'd1;
            if (!iq_if.flush_i && pop_n == CW'(1) && perf_single_q != '1)
                perf_single_q <= perf_single_q + 32'd1;
            if (!iq_if.flush_i && pop_n == CW'(2) && perf_dual_q != '1)
                perf_dual_q <= perf_dual_q + 32'd1;
        end
    end

    assign perf_empty_o  = perf_empty_q;
    assign perf_single_o = perf_single_q;
    assign perf_dual_o   = perf_dual_q;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Randomized + directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = IQ_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH)) ifc ();

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_empty, perf_single, perf_dual;
    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .iq_if(ifc.slave),
        .perf_empty_o(perf_empty), .perf_single_o(perf_single), .perf_dual_o(perf_dual));
`else
    inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .iq_if(ifc.slave));
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: list of occupied entries, oldest first.
    iq_entry_t mq[$];
    bit        mflag;
    int        m_empty, m_single, m_dual;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        iq_entry_t e1, e2;
        e1 = (mq.size() >= 1) ? mq[0] : '0;
        e2 = (mq.size() >= 2) ? mq[1] : '0;
        chk("count",    128'(ifc.count_o),           128'(mq.size()));
        chk("full",     128'(ifc.full_o),            128'(mq.size() >= DEPTH - 1));
        chk("issue_en", 128'(ifc.issue_en_o),        128'(mq.size() >= 2));
        chk("dslot",    128'(ifc.is_in_delayslot_o), 128'(mflag && mq.size() >= 1));
        chk("inst1",    128'(ifc.inst1_o),           128'(e1.inst));
        chk("addr1",    128'(ifc.inst1_addr_o),      128'(e1.addr));
        chk("corr1",    128'(ifc.inst1_corr_o),      128'(e1.corr));
        chk("inst2",    128'(ifc.inst2_o),           128'(e2.inst));
        chk("addr2",    128'(ifc.inst2_addr_o),      128'(e2.addr));
        chk("corr2",    128'(ifc.inst2_corr_o),      128'(e2.corr));
    endtask

    task automatic drive_idle();
        ifc.flush_i = 0; ifc.fetch_valid1_i = 0; ifc.fetch_valid2_i = 0;
        ifc.issued_i = 0; ifc.issue_mode_i = SINGLE_ISSUE; ifc.ninst_in_delayslot_i = 0;
        ifc.fetch_inst1_i = '0; ifc.fetch_inst2_i = '0;
        ifc.fetch_addr1_i = '0; ifc.fetch_addr2_i = '0;
        ifc.fetch_corr1_i = '0; ifc.fetch_corr2_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); mflag = 0;
        m_empty = 0; m_single = 0; m_dual = 0;
        check_all();
    endtask

    // One clock: drive at negedge, advance model, check at the next negedge.
    task automatic cyc(input bit fl, input bit v1, input bit v2, input bit iss,
                       input bit md, input bit ni, input logic [31:0] a1);
        iq_entry_t w1, w2;
        int pop, sz;
        w1.inst = $urandom(); w1.addr = a1;
        w1.corr = SIZE_OF_CORR_PACK'({$urandom(), $urandom(), $urandom()});
        w2.inst = $urandom(); w2.addr = a1 + 32'd4;
        w2.corr = SIZE_OF_CORR_PACK'({$urandom(), $urandom(), $urandom()});
        ifc.flush_i = fl; ifc.fetch_valid1_i = v1; ifc.fetch_valid2_i = v2;
        ifc.issued_i = iss; ifc.issue_mode_i = md; ifc.ninst_in_delayslot_i = ni;
        ifc.fetch_inst1_i = w1.inst; ifc.fetch_addr1_i = w1.addr; ifc.fetch_corr1_i = w1.corr;
        ifc.fetch_inst2_i = w2.inst; ifc.fetch_addr2_i = w2.addr; ifc.fetch_corr2_i = w2.corr;

        sz  = mq.size();
        pop = !iss ? 0 : (md == DUAL_ISSUE) ? 2 : 1;
        if (pop > sz) pop = sz;
        if (sz == 0) m_empty++;
        if (!fl && pop == 1) m_single++;
        if (!fl && pop == 2) m_dual++;
        if (fl) begin
            mq.delete(); mflag = 0;
        end else begin
            if (iss && md == SINGLE_ISSUE && ni) mflag = 1;
            else if (pop > 0) mflag = 0;
            repeat (pop) void'(mq.pop_front());
            if (sz < DEPTH - 1 && v1) begin
                mq.push_back(w1);
                if (v2) mq.push_back(w2);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        drive_idle();
        @(negedge clk);
        do_reset();
        chk("rst_count", 128'(ifc.count_o), 128'(0));
        chk("rst_full",  128'(ifc.full_o),  128'(0));

        // Fill with 2/cycle, PCs 0x1000..0x103C; extra writes must be dropped.
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 1, 0, SINGLE_ISSUE, 0, 32'h1000 + 32'(8 * k));
            if (k == 6) chk("fill7_full", 128'(ifc.full_o), 128'(0));
        end
        chk("fill_full",  128'(ifc.full_o),  128'(1));
        chk("fill_count", 128'(ifc.count_o), 128'(16));
        cyc(0, 1, 1, 0, SINGLE_ISSUE, 0, 32'h2000);
        chk("drop_count", 128'(ifc.count_o), 128'(16));

        // Drain with dual issue each cycle.
        for (int k = 0; k < 8; k++) begin
            chk("dual_pc", 128'(ifc.inst1_addr_o), 128'(32'h1000 + 32'(8 * k)));
            cyc(0, 0, 0, 1, DUAL_ISSUE, 0, 32'h0);
            chk("dual_cnt", 128'(ifc.count_o), 128'(14 - 2 * k));
        end

        // Wrap the pointers: one entry in flight, then refill across the end.
        cyc(0, 1, 0, 0, SINGLE_ISSUE, 0, 32'h3000);
        chk("one_inst2", 128'(ifc.inst2_o), 128'(0));
        cyc(0, 0, 0, 1, DUAL_ISSUE, 0, 32'h0);
        chk("sat_count", 128'(ifc.count_o), 128'(0));
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0, SINGLE_ISSUE, 0, 32'h4000 + 32'(8 * k));
        for (int k = 0; k < 8; k++) begin
            chk("wrap_pc", 128'(ifc.inst1_addr_o), 128'(32'h4000 + 32'(8 * k)));
            cyc(0, 0, 0, 1, DUAL_ISSUE, 0, 32'h0);
        end

        // Branch single-issued alone, queue empty 3 cycles, then its delay slot arrives.
        cyc(0, 1, 0, 0, SINGLE_ISSUE, 0, 32'h5000);
        cyc(0, 0, 0, 1, SINGLE_ISSUE, 1, 32'h0);
        chk("ds_empty", 128'(ifc.is_in_delayslot_o), 128'(0));
        repeat (3) cyc(0, 0, 0, 0, SINGLE_ISSUE, 0, 32'h0);
        cyc(0, 1, 1, 0, SINGLE_ISSUE, 0, 32'h5004);
        chk("ds_set", 128'(ifc.is_in_delayslot_o), 128'(1));
        cyc(0, 0, 0, 1, SINGLE_ISSUE, 0, 32'h0);
        chk("ds_clr", 128'(ifc.is_in_delayslot_o), 128'(0));
        cyc(0, 0, 0, 1, SINGLE_ISSUE, 0, 32'h0);

        // Flush with simultaneous push and pop at count 6.
        repeat (3) cyc(0, 1, 1, 0, SINGLE_ISSUE, 0, 32'h6000);
        chk("pre_flush", 128'(ifc.count_o), 128'(6));
        cyc(1, 1, 1, 1, DUAL_ISSUE, 0, 32'h7000);
        chk("flush_cnt", 128'(ifc.count_o),    128'(0));
        chk("flush_en",  128'(ifc.issue_en_o), 128'(0));
        chk("flush_ds",  128'(ifc.is_in_delayslot_o), 128'(0));

        // Randomized traffic; flush only once any delay slot has issued.
        for (int i = 0; i < 1500; i++) begin
            bit fl, v1, v2, iss, md, ni;
            v1  = ($urandom_range(0, 3) != 0);
            v2  = $urandom_range(0, 1);
            iss = ($urandom_range(0, 2) != 0);
            md  = $urandom_range(0, 1);
            ni  = (md == SINGLE_ISSUE) && ($urandom_range(0, 3) == 0);
            fl  = !mflag && ($urandom_range(0, 49) == 0);
            cyc(fl, v1, v2, iss, md, ni, $urandom());
        end

`ifdef IQ_PERF_CNT_EN
        chk("perf_empty",  128'(perf_empty),  128'(m_empty));
        chk("perf_single", 128'(perf_single), 128'(m_single));
        chk("perf_dual",   128'(perf_dual),   128'(m_dual));
`endif

        do_reset();
        chk("rst2_en", 128'(ifc.issue_en_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
